// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn sequencer/referee: validates one-hot moves, commits them, then judges win/draw.
// Outcome one cycle after commit (busy during that cycle); moves dropped while busy or game over.
module ttt_turn_ctrl #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [8:0] move,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn,
  output logic       busy,
  output logic       illegal,
  output logic [3:0] last_idx,
  output logic [3:0] move_count,
  output logic [1:0] winner,
  output logic       game_over
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  state_t     state, state_nxt;
  logic [8:0] board_x_nxt, board_o_nxt;
  logic       turn_nxt, busy_nxt, illegal_nxt, game_over_nxt;
  logic [3:0] last_idx_nxt, move_count_nxt;
  logic [1:0] winner_nxt;

  logic [8:0] occupied;
  logic       move_onehot;
  logic       move_free;
  logic       move_legal;
  logic [3:0] move_idx;
  logic [8:0] mover_map;
  logic       mover_line;

  // Any of the three rows, three columns or two diagonals fully owned.
  function automatic logic line_complete(input logic [8:0] m);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (m[3*r] && m[3*r+1] && m[3*r+2]) hit = 1'b1;
      if (m[r] && m[r+3] && m[r+6])       hit = 1'b1;
    end
    if (m[0] && m[4] && m[8]) hit = 1'b1;
    if (m[2] && m[4] && m[6]) hit = 1'b1;
    return hit;
  endfunction

  assign occupied    = board_x | board_o;
  assign move_onehot = (move != 9'd0) && ((move & (move - 9'd1)) == 9'd0);
  assign move_free   = (move & occupied) == 9'd0;
  assign move_legal  = move_onehot && move_free;
  assign mover_map   = turn ? board_o : board_x;
  assign mover_line  = line_complete(mover_map);

  // Only meaningful when move_onehot; otherwise the lowest set bit wins.
  always_comb begin
    move_idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (move[i]) move_idx = 4'(i);
    end
  end

  always_comb begin
    state_nxt      = state;
    board_x_nxt    = board_x;
    board_o_nxt    = board_o;
    turn_nxt       = turn;
    illegal_nxt    = 1'b0;
    last_idx_nxt   = last_idx;
    move_count_nxt = move_count;
    winner_nxt     = winner;

    if (new_game) begin
      state_nxt      = PLAY;
      board_x_nxt    = 9'd0;
      board_o_nxt    = 9'd0;
      turn_nxt       = FIRST_PLAYER;
      last_idx_nxt   = 4'd0;
      move_count_nxt = 4'd0;
      winner_nxt     = WIN_NONE;
    end else begin
      unique case (state)
        PLAY: begin
          if (move_valid) begin
            if (move_legal) begin
              if (turn) board_o_nxt = board_o | move;
              else      board_x_nxt = board_x | move;
              last_idx_nxt   = move_idx;
              move_count_nxt = move_count + 4'd1;
              state_nxt      = CHECK;
            end else begin
              illegal_nxt = 1'b1;
            end
          end
        end
        CHECK: begin
          // A win on the ninth move takes precedence over the draw.
          if (mover_line) begin
            winner_nxt = turn ? WIN_O : WIN_X;
            state_nxt  = DONE;
          end else if (move_count == 4'd9) begin
            winner_nxt = WIN_DRAW;
            state_nxt  = DONE;
          end else begin
            turn_nxt  = ~turn;
            state_nxt = PLAY;
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = PLAY;
        end
      endcase
    end

    busy_nxt      = (state_nxt == CHECK);
    game_over_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PLAY;
      board_x    <= 9'd0;
      board_o    <= 9'd0;
      turn       <= FIRST_PLAYER;
      busy       <= 1'b0;
      illegal    <= 1'b0;
      last_idx   <= 4'd0;
      move_count <= 4'd0;
      winner     <= WIN_NONE;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      board_x    <= board_x_nxt;
      board_o    <= board_o_nxt;
      turn       <= turn_nxt;
      busy       <= busy_nxt;
      illegal    <= illegal_nxt;
      last_idx   <= last_idx_nxt;
      move_count <= move_count_nxt;
      winner     <= winner_nxt;
      game_over  <= game_over_nxt;
    end
  end

endmodule
